data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram_if.sv | 33 +++
 rtl/data_ram.sv | 237 +++++++++++++++++++++++
 tb/tb_data_ram.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/data_ram_if.sv
// data_ram_if -- request/response bundle between a control unit and data_ram.
//
// Signals:
//   MFA      request strobe from the control unit (memory function activate)
//   RW       access direction, 1 = read, 0 = write
//   Type     access size: 00 byte, 01 halfword, 10 word, 11 illegal
//   Address  byte address into the 256-byte store
//   DataIn   right-justified write data
//   DataOut  right-justified, zero-extended read data (registered in the RAM)
//   MOC      memory operation complete (registered in the RAM)
//   Err      access fault, meaningful while MOC is high
//
// Modports: master = control unit side, slave = data_ram side.
interface data_ram_if;
  logic        MFA;
  logic        RW;
  logic [1:0]  Type;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Err;

  modport master (
    output MFA, RW, Type, Address, DataIn,
    input  DataOut, MOC, Err
  );

  modport slave (
    input  MFA, RW, Type, Address, DataIn,
    output DataOut, MOC, Err
  );
endinterface

// File: rtl/data_ram.sv
// data_ram -- 256 x 8 big-endian data memory with a MFA/MOC handshake.
//
// A request is captured on the first rising edge that sees MFA=1 in IDLE.
// The access executes WAIT_CYCLES edges later, at which point MOC rises
// together with Err and (for reads) DataOut. MOC then stays high until the
// control unit drops MFA; a fresh request needs at least one IDLE cycle.
//
// Ports:
//   Clk    rising-edge system clock
//   Reset  asynchronous, active-low reset (memory contents are not cleared)
//   bus    data_ram_if.slave: MFA, RW, Type, Address, DataIn in;
//          DataOut, MOC, Err out (all outputs registered)
//
// Parameter:
//   WAIT_CYCLES  edges from capture to MOC assertion, legal range 1..15
module data_ram #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic      Clk,
  input  logic      Reset,
  data_ram_if.slave bus
);

  // Reject out-of-range wait counts at elaboration time.
  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
    $error("data_ram: WAIT_CYCLES must be in 1..15");
  end

  // Counter value on the edge where the access executes.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_s;
  logic        capture_s;
  logic        execute_s;
  logic        release_s;

  logic        rw_r;
  logic [1:0]  type_r;
  logic [7:0]  addr_r;
  logic [31:0] din_r;

  logic [31:0] dout_r;
  logic        moc_r;
  logic        err_r;

  logic [7:0]  mem_r [0:255];

  logic [7:0]  addr1_s;
  logic [7:0]  addr2_s;
  logic [7:0]  addr3_s;
  logic        fault_s;
  logic        wr_en_s;
  logic [31:0] rd_data_s;

  // Size/alignment check: halfwords need A[0]=0, words need A[1:0]=00,
  // and the reserved size code always faults.
  function automatic logic access_fault(input logic [1:0] size,
                                        input logic [7:0] addr);
    logic fault;
    case (size)
      2'b00:   fault = 1'b0;
      2'b01:   fault = addr[0];
      2'b10:   fault = |addr[1:0];
      default: fault = 1'b1;
    endcase
    return fault;
  endfunction

  // Aligned accesses never cross the top of the store, so plain 8-bit
  // increments are enough for the trailing byte lanes.
  assign addr1_s = addr_r + 8'd1;
  assign addr2_s = addr_r + 8'd2;
  assign addr3_s = addr_r + 8'd3;
  assign fault_s = access_fault(type_r, addr_r);

  // Writes only happen on the execute edge; an async reset puts the FSM in
  // IDLE, which kills a pending write before it reaches the array.
  assign wr_en_s = execute_s & ~rw_r & ~fault_s;

  // FSM state and wait counter register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // FSM next-state and control strobes.
  // The counter holds the number of edges seen since capture; the access
  // fires when it reaches WAIT_CYCLES, so WAIT_CYCLES=1 executes on the
  // very next edge after capture.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    execute_s = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.MFA) begin
          capture_s = 1'b1;
          state_s   = BUSY;
          cnt_s     = 4'd1;
        end else begin
          state_s   = IDLE;
          cnt_s     = 4'd0;
        end
      end
      BUSY: begin
        // MFA is deliberately ignored here: a started access always completes.
        if (cnt_r == WAIT_LAST) begin
          execute_s = 1'b1;
          state_s   = DONE;
          cnt_s     = 4'd0;
        end else begin
          state_s   = BUSY;
          cnt_s     = cnt_r + 4'd1;
        end
      end
      DONE: begin
        // Holding MFA high here keeps MOC up but never starts a new access.
        if (!bus.MFA) begin
          release_s = 1'b1;
          state_s   = IDLE;
        end else begin
          state_s   = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Request latch: the whole operation runs on values captured at edge 0.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rw_r   <= 1'b0;
      type_r <= 2'b00;
      addr_r <= 8'h00;
      din_r  <= 32'h0000_0000;
    end else if (capture_s) begin
      rw_r   <= bus.RW;
      type_r <= bus.Type;
      addr_r <= bus.Address;
      din_r  <= bus.DataIn;
    end else begin
      rw_r   <= rw_r;
      type_r <= type_r;
      addr_r <= addr_r;
      din_r  <= din_r;
    end
  end

  // Big-endian read assembly from the latched request.
  always_comb begin
    rd_data_s = 32'h0000_0000;
    case (type_r)
      2'b00:   rd_data_s = {24'h00_0000, mem_r[addr_r]};
      2'b01:   rd_data_s = {16'h0000, mem_r[addr_r], mem_r[addr1_s]};
      2'b10:   rd_data_s = {mem_r[addr_r], mem_r[addr1_s],
                            mem_r[addr2_s], mem_r[addr3_s]};
      default: rd_data_s = 32'h0000_0000;
    endcase
  end

  // Storage array, deliberately without reset so it maps onto RAM.
  always_ff @(posedge Clk) begin
    if (wr_en_s) begin
      case (type_r)
        2'b00: begin
          mem_r[addr_r]  <= din_r[7:0];
        end
        2'b01: begin
          mem_r[addr_r]  <= din_r[15:8];
          mem_r[addr1_s] <= din_r[7:0];
        end
        2'b10: begin
          mem_r[addr_r]  <= din_r[31:24];
          mem_r[addr1_s] <= din_r[23:16];
          mem_r[addr2_s] <= din_r[15:8];
          mem_r[addr3_s] <= din_r[7:0];
        end
        default: begin
          mem_r[addr_r]  <= mem_r[addr_r];
        end
      endcase
    end
  end

  // Response registers: MOC/Err set on execute and clear on release.
  // DataOut only moves on a read completion or a fault; a clean write
  // leaves the last read value in place.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      moc_r  <= 1'b0;
      err_r  <= 1'b0;
      dout_r <= 32'h0000_0000;
    end else if (execute_s) begin
      moc_r <= 1'b1;
      err_r <= fault_s;
      if (fault_s) begin
        dout_r <= 32'h0000_0000;
      end else if (rw_r) begin
        dout_r <= rd_data_s;
      end else begin
        dout_r <= dout_r;
      end
    end else if (release_s) begin
      moc_r  <= 1'b0;
      err_r  <= 1'b0;
      dout_r <= dout_r;
    end else begin
      moc_r  <= moc_r;
      err_r  <= err_r;
      dout_r <= dout_r;
    end
  end

  assign bus.DataOut = dout_r;
  assign bus.MOC     = moc_r;
  assign bus.Err     = err_r;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram -- scoreboard bench for data_ram with WAIT_CYCLES=2.
// Stimulus pushes the hand-computed {Err, DataOut} expected at completion;
// an independent monitor pops on every rising MOC and compares.
module tb_data_ram;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_ram_if bus ();

  data_ram #(.WAIT_CYCLES(2)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] dout;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pushes = 0;
  int   pops   = 0;
  logic moc_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every rising MOC must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.MOC === 1'b1 && moc_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_moc: got MOC rise with empty scoreboard, expected none");
      end else begin
        mon_e = sb_q.pop_front();
        pops++;
        check($sformatf("err_%0d", mon_e.id), {31'b0, bus.Err}, {31'b0, mon_e.err});
        check($sformatf("dout_%0d", mon_e.id), bus.DataOut, mon_e.dout);
      end
    end
    moc_prev <= bus.MOC;
  end

  // One complete handshake; inputs are scrambled right after capture.
  task automatic access(input int id, input logic rw, input logic [1:0] ty,
                        input logic [7:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_dout,
                        input bit drop_early, input int hold);
    int   edges;
    exp_t e;
    e.err  = exp_err;
    e.dout = exp_dout;
    e.id   = id;
    sb_q.push_back(e);
    pushes++;
    bus.MFA     = 1'b1;
    bus.RW      = rw;
    bus.Type    = ty;
    bus.Address = a;
    bus.DataIn  = d;
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    bus.Address = a ^ 8'hFF;
    bus.DataIn  = ~d;
    bus.RW      = ~rw;
    bus.Type    = ty ^ 2'b11;
    if (drop_early) bus.MFA = 1'b0;
    while (bus.MOC !== 1'b1 && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check($sformatf("latency_%0d", id), 32'(edges), 32'd2);
    if (!drop_early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check($sformatf("moc_hold_%0d", id), {31'b0, bus.MOC}, 32'd1);
      end
      bus.MFA = 1'b0;
    end
    @(negedge clk);
    check($sformatf("moc_low_%0d", id), {31'b0, bus.MOC}, 32'd0);
    check($sformatf("err_low_%0d", id), {31'b0, bus.Err}, 32'd0);
    check($sformatf("dout_idle_%0d", id), bus.DataOut, exp_dout);
  endtask

  // Word write interrupted by reset while BUSY; nothing should complete.
  task automatic reset_during_busy();
    bus.MFA     = 1'b1;
    bus.RW      = 1'b0;
    bus.Type    = 2'b10;
    bus.Address = 8'h24;
    bus.DataIn  = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_busy_moc", {31'b0, bus.MOC}, 32'd0);
    check("rst_busy_err", {31'b0, bus.Err}, 32'd0);
    check("rst_busy_dout", bus.DataOut, 32'h0000_0000);
    bus.MFA = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    bus.MFA     = 1'b0;
    bus.RW      = 1'b0;
    bus.Type    = 2'b00;
    bus.Address = 8'h00;
    bus.DataIn  = 32'h0000_0000;
    #3 reset = 1'b0;
    #1;
    check("reset_moc", {31'b0, bus.MOC}, 32'd0);
    check("reset_err", {31'b0, bus.Err}, 32'd0);
    check("reset_dout", bus.DataOut, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;

    //     id rw    type   addr   data           err   expected DataOut  drop hold
    access(1, 1'b0, 2'b10, 8'h10, 32'hA1B2_C3D4, 1'b0, 32'h0000_0000, 1'b0, 0);
    access(2, 1'b1, 2'b00, 8'h10, 32'h0000_0000, 1'b0, 32'h0000_00A1, 1'b0, 0);
    access(3, 1'b1, 2'b00, 8'h13, 32'h0000_0000, 1'b0, 32'h0000_00D4, 1'b0, 1);
    access(4, 1'b1, 2'b01, 8'h12, 32'h0000_0000, 1'b0, 32'h0000_C3D4, 1'b0, 0);
    access(5, 1'b1, 2'b10, 8'h11, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0);
    access(6, 1'b0, 2'b01, 8'h11, 32'h0000_BEEF, 1'b1, 32'h0000_0000, 1'b0, 0);
    access(7, 1'b1, 2'b10, 8'h10, 32'h0000_0000, 1'b0, 32'hA1B2_C3D4, 1'b0, 0);
    access(8, 1'b0, 2'b00, 8'h20, 32'h0000_005A, 1'b0, 32'hA1B2_C3D4, 1'b1, 0);
    access(9, 1'b1, 2'b00, 8'h20, 32'h0000_0000, 1'b0, 32'h0000_005A, 1'b0, 0);
    access(10, 1'b0, 2'b10, 8'h24, 32'h0102_0304, 1'b0, 32'h0000_005A, 1'b0, 0);
    reset_during_busy();
    access(11, 1'b1, 2'b10, 8'h24, 32'h0000_0000, 1'b0, 32'h0102_0304, 1'b0, 0);
    access(12, 1'b1, 2'b01, 8'h24, 32'h0000_0000, 1'b0, 32'h0000_0102, 1'b0, 10);
    access(13, 1'b1, 2'b00, 8'h27, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0, 0);
    access(14, 1'b1, 2'b11, 8'h00, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0);
    access(15, 1'b0, 2'b01, 8'h30, 32'hDEAD_1234, 1'b0, 32'h0000_0000, 1'b0, 0);
    access(16, 1'b1, 2'b01, 8'h30, 32'h0000_0000, 1'b0, 32'h0000_1234, 1'b0, 0);
    access(17, 1'b1, 2'b00, 8'h31, 32'h0000_0000, 1'b0, 32'h0000_0034, 1'b0, 0);
    access(18, 1'b1, 2'b10, 8'h12, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    check("sb_pops", 32'(pops), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
